// File: rtl/processor_top_core.sv
// Multicycle 16-bit accumulator-free core with 4 GPRs and unified memory.
// Five cycles per instruction: fetch, decode, execute, mem, writeback.

module processor_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        ra,
  input  logic [1:0]        rb,
  input  logic [1:0]        rc,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rc_data
);

  logic [DATA_W-1:0] regs [0:3];

  // combinational read ports
  always_comb begin
    ra_data = regs[ra];
    rb_data = regs[rb];
    rc_data = regs[rc];
  end

  // single synchronous write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we)
      regs[waddr] <= wdata;
  end

endmodule

module processor_mem #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  // asynchronous read
  always_comb begin
    rdata = mem[raddr];
  end

  // synchronous write; contents survive reset
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

endmodule

module processor_top_core #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state;
  state_t state_n;

  logic [7:0]        pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] alu_out;

  logic [2:0]        opc;
  logic [DATA_W-1:0] imm;

  logic is_alu;
  logic is_load;
  logic is_store;
  logic is_jmp;
  logic is_halt;

  logic ld_ir;
  logic ld_ops;
  logic ld_y;
  logic ld_mdr;
  logic ld_pc;
  logic rf_we;
  logic mem_we;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rf_wdata;
  logic [7:0]        mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign opc = ir[15:13];
  assign imm = {{(DATA_W-9){1'b0}}, ir[8:0]};

  // opcode decode; unknown opcodes fall through as a NOP
  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = 1'b0;
    if (!$isunknown(opc)) begin
      case (opc)
        3'b000,
        3'b001,
        3'b010,
        3'b011:  is_alu   = 1'b1;
        3'b100:  is_load  = 1'b1;
        3'b101:  is_store = 1'b1;
        3'b110:  is_jmp   = 1'b1;
        default: is_halt  = 1'b1;
      endcase
    end
  end

  // ALU: address add for LOAD/STORE, logic/arith for R-type
  always_comb begin
    alu_out = alu_a + alu_b;
    case (opc)
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      default: alu_out = alu_a + alu_b;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:   state_n = S_DECODE;
      S_DECODE:  state_n = is_halt ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_n = S_MEM;
      S_MEM:     state_n = S_WB;
      S_WB:      state_n = S_FETCH;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_FETCH;
    endcase
  end

  // per-state control strobes; writes are suppressed under reset
  always_comb begin
    ld_ir  = 1'b0;
    ld_ops = 1'b0;
    ld_y   = 1'b0;
    ld_mdr = 1'b0;
    ld_pc  = 1'b0;
    rf_we  = 1'b0;
    mem_we = 1'b0;
    unique case (1'b1)
      state == S_FETCH:   ld_ir  = 1'b1;
      state == S_DECODE:  ld_ops = 1'b1;
      state == S_EXECUTE: ld_y   = 1'b1;
      state == S_MEM: begin
        ld_mdr = 1'b1;
        mem_we = is_store & ~reset;
      end
      state == S_WB: begin
        ld_pc = 1'b1;
        rf_we = (is_alu | is_load) & ~reset;
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      ir    <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_y <= '0;
      mdr   <= '0;
    end else begin
      if (ld_ir)
        ir <= mem_rdata;
      if (ld_ops) begin
        alu_a <= rs1_data;
        alu_b <= (is_load | is_store) ? imm : rs2_data;
      end
      if (ld_y)
        alu_y <= alu_out;
      if (ld_mdr)
        mdr <= mem_rdata;
      if (ld_pc)
        pc <= is_jmp ? ir[7:0] : pc + 8'd1;
    end
  end

  assign mem_raddr = (state == S_FETCH) ? pc : alu_y[7:0];
  assign rf_wdata  = is_load ? mdr : alu_y;

  processor_regfile #(
    .DATA_W (DATA_W)
  ) regfile (
    .clk     (clk),
    .we      (rf_we),
    .waddr   (ir[12:11]),
    .wdata   (rf_wdata),
    .ra      (ir[10:9]),
    .rb      (ir[8:7]),
    .rc      (ir[12:11]),
    .ra_data (rs1_data),
    .rb_data (rs2_data),
    .rc_data (rs_data)
  );

  processor_mem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (alu_y[7:0]),
    .wdata (rs_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_processor_top_core.sv
// Directed bench for processor_top_core.
// Programs are preloaded through hierarchy while reset is held.

module tb_processor_top_core;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  processor_top_core dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    run(2);
    for (int i = 0; i < 256; i++)
      dut.mem.mem[i] = 16'hE000;
  endtask

  task automatic set_regs(input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2, input logic [15:0] r3);
    dut.regfile.regs[0] = r0;
    dut.regfile.regs[1] = r1;
    dut.regfile.regs[2] = r2;
    dut.regfile.regs[3] = r3;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;

    // reset state
    hold_reset();
    check("rst_pc", {8'h00, dut.pc}, 16'h0000);
    check("rst_ir", dut.ir, 16'h0000);
    check("rst_alu_a", dut.alu_a, 16'h0000);

    // ADD x1=x2+x3 ; SUB x0=x1-x3 ; HALT
    set_regs(16'h0000, 16'h0000, 16'h0005, 16'h000A);
    dut.mem.mem[0] = 16'h0D80;
    dut.mem.mem[1] = 16'h2380;
    dut.mem.mem[2] = 16'hE000;
    reset = 1'b0;
    run(2);
    check("decode_alu_a", dut.alu_a, 16'h0005);
    run(13);
    check("add_x1", dut.regfile.regs[1], 16'h000F);
    check("sub_x0", dut.regfile.regs[0], 16'h0005);
    check("keep_x3", dut.regfile.regs[3], 16'h000A);
    check("keep_x2", dut.regfile.regs[2], 16'h0005);
    check("halt_pc", {8'h00, dut.pc}, 16'h0002);
    run(10);
    check("halt_pc_hold", {8'h00, dut.pc}, 16'h0002);

    // LOAD x2 = mem[x0+3]
    hold_reset();
    set_regs(16'h0005, 16'h0000, 16'h0000, 16'h0000);
    dut.mem.mem[8] = 16'hBEEF;
    dut.mem.mem[0] = 16'h9003;
    reset = 1'b0;
    run(5);
    check("load_x2", dut.regfile.regs[2], 16'hBEEF);
    check("load_pc", {8'h00, dut.pc}, 16'h0001);

    // STORE mem[x1+2] = x2
    hold_reset();
    set_regs(16'h1111, 16'h000F, 16'h1234, 16'h3333);
    dut.mem.mem[0] = 16'hB202;
    reset = 1'b0;
    run(3);
    check("store_before", dut.mem.mem[17], 16'hE000);
    run(1);
    check("store_mem17", dut.mem.mem[17], 16'h1234);
    run(1);
    check("store_x0", dut.regfile.regs[0], 16'h1111);
    check("store_x1", dut.regfile.regs[1], 16'h000F);
    check("store_x2", dut.regfile.regs[2], 16'h1234);
    check("store_x3", dut.regfile.regs[3], 16'h3333);

    // ADD overflow: x2 = x0 + x1
    hold_reset();
    set_regs(16'hFFFF, 16'h0002, 16'h0000, 16'h0000);
    dut.mem.mem[0] = 16'h1080;
    reset = 1'b0;
    run(5);
    check("add_wrap", dut.regfile.regs[2], 16'h0001);

    // SUB borrow: x3 = x0 - x1
    hold_reset();
    set_regs(16'h0000, 16'h0001, 16'h0000, 16'h0000);
    dut.mem.mem[0] = 16'h3880;
    reset = 1'b0;
    run(5);
    check("sub_wrap", dut.regfile.regs[3], 16'hFFFF);

    // LOAD address wrap: x1 = mem[(0xFF+2) & 0xFF] = mem[1]
    hold_reset();
    set_regs(16'h00FF, 16'h0000, 16'h0000, 16'h0000);
    dut.mem.mem[0] = 16'h8802;
    dut.mem.mem[1] = 16'hE000;
    reset = 1'b0;
    run(5);
    check("load_addr_wrap", dut.regfile.regs[1], 16'hE000);

    // JMP 5 then HALT at 5
    hold_reset();
    set_regs(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    dut.mem.mem[0] = 16'hC005;
    dut.mem.mem[5] = 16'hE000;
    reset = 1'b0;
    run(5);
    check("jmp_pc", {8'h00, dut.pc}, 16'h0005);
    run(10);
    check("jmp_halt_hold", {8'h00, dut.pc}, 16'h0005);
    reset = 1'b1;
    run(1);
    check("jmp_rst_pc", {8'h00, dut.pc}, 16'h0000);
    check("jmp_rst_ir", dut.ir, 16'h0000);
    check("jmp_rst_alu_a", dut.alu_a, 16'h0000);
    check("jmp_rst_x0", dut.regfile.regs[0], 16'h0001);
    check("jmp_rst_x3", dut.regfile.regs[3], 16'h0004);

    // reset on the WB edge aborts the register write
    hold_reset();
    set_regs(16'h0010, 16'h0020, 16'h0000, 16'h0000);
    dut.mem.mem[0] = 16'h1080;
    reset = 1'b0;
    run(4);
    reset = 1'b1;
    run(1);
    check("abort_x2", dut.regfile.regs[2], 16'h0000);
    check("abort_pc", {8'h00, dut.pc}, 16'h0000);
    reset = 1'b0;
    run(5);
    check("restart_x2", dut.regfile.regs[2], 16'h0030);
    check("restart_pc", {8'h00, dut.pc}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
